// File: rtl/dsconv_pkg.sv
// Shared types for the depthwise-separable conv pipeline: pixel width,
// signed pixel type and the pooling FSM state encoding.
package dsconv_pkg;
   localparam int DATA_W = 18;
   typedef logic signed [DATA_W-1:0] pixel_t;
   typedef enum logic {S_FILL = 1'b0, S_EMIT = 1'b1} state_t;
endpackage

// File: rtl/dsconv_pool_linebuf.sv
// Half-width line buffer holding the horizontal-pair maxima of the last even row.
// Synchronous write, combinational read so the odd-row pixel can complete its window in one cycle.
module dsconv_pool_linebuf #(
   parameter int DEPTH  = 14,
   parameter int DATA_W = 18,
   parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [AW-1:0]            waddr,
   input  logic signed [DATA_W-1:0] wdata,
   input  logic [AW-1:0]            raddr,
   output logic signed [DATA_W-1:0] rdata
);
   logic signed [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;

   assign rdata = mem[raddr];
endmodule

// File: rtl/dsconv_block_maxpool.sv
// 2x2 stride-2 max pooling over a raster-order pixel stream with no backpressure.
// Even rows fill the line buffer with pair maxima; odd rows finish each window.
module dsconv_block_maxpool
   import dsconv_pkg::*;
#(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int DATA_W = dsconv_pkg::DATA_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic signed [DATA_W-1:0] x,
   output logic signed [DATA_W-1:0] output_pixel,
   output logic                     ready,
   output logic                     frame_done
);
   localparam int HALF = IMG_W / 2;
   localparam int CW   = $clog2(IMG_W);
   localparam int RW   = $clog2(IMG_H);
   localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

   generate
      if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2) begin : g_bad_dims
         $error("dsconv_block_maxpool: IMG_W and IMG_H must be even and >= 2");
      end
   endgenerate

   function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   state_t                   state;
   logic [CW-1:0]            col;
   logic [RW-1:0]            row;
   logic signed [DATA_W-1:0] pair;
   logic signed [DATA_W-1:0] lb_rd;
   logic [AW-1:0]            lb_addr;
   logic                     lb_we;
   logic                     col_last, row_last;

   assign col_last = (col == CW'(IMG_W - 1));
   assign row_last = (row == RW'(IMG_H - 1));
   assign lb_addr  = AW'(col >> 1);
   assign lb_we    = start && (state == S_FILL) && col[0];

   dsconv_pool_linebuf #(.DEPTH(HALF), .DATA_W(DATA_W), .AW(AW)) u_linebuf (
      .clk   (clk),
      .we    (lb_we),
      .waddr (lb_addr),
      .wdata (smax(pair, x)),
      .raddr (lb_addr),
      .rdata (lb_rd)
   );

   // Counters, pair register and FSM move only on accepted pixels; ready/frame_done are single-cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_FILL;
         col          <= '0;
         row          <= '0;
         pair         <= '0;
         output_pixel <= '0;
         ready        <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         ready      <= 1'b0;
         frame_done <= 1'b0;
         if (start) begin
            if (!col[0]) begin
               pair <= x;
            end else if (state == S_EMIT) begin
               output_pixel <= smax(lb_rd, smax(pair, x));
               ready        <= 1'b1;
               frame_done   <= row_last && col_last;
            end
            if (col_last) begin
               col   <= '0;
               row   <= row_last ? '0 : row + 1'b1;
               state <= (state == S_FILL) ? S_EMIT : S_FILL;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_dsconv_block_maxpool.sv
// Scoreboard bench for the 4x4 max-pool: the driver pushes hand-computed window
// maxima when it issues each completing pixel; a monitor pops them on every ready pulse.
module tb_dsconv_block_maxpool;
   localparam int W = 4, H = 4, DW = 18;

   typedef struct {
      logic signed [DW-1:0] v;
      logic                 fd;
      int                   due;
   } exp_t;

   logic                 clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic signed [DW-1:0] x = '0;
   logic signed [DW-1:0] output_pixel;
   logic                 ready, frame_done;

   int   total = 0, bad = 0, cyc = 0;
   exp_t sb[$];

   dsconv_block_maxpool #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .x            (x),
      .output_pixel (output_pixel),
      .ready        (ready),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: sample 2 time units after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #2;
         if (ready) begin
            if (sb.size() == 0) begin
               chk("spurious_ready", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("pixel", output_pixel, e.v);
               chk("frame_done", frame_done, e.fd);
               chk("latency", cyc, e.due);
            end
         end else if (frame_done) begin
            chk("frame_done_without_ready", 1, 0);
         end
      end
   end

   // mode 0: start held high, 1: alternate 1-0, 2: random gaps 0..3. Sends first n pixels.
   task automatic send_frame(input int px[16], input int ex[4], input int mode, input int n);
      int k = 0;
      for (int i = 0; i < n; i++) begin
         int g;
         g = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 3));
         for (int j = 0; j < g; j++) begin
            @(negedge clk);
            start = 1'b0;
            x     = DW'($urandom);
         end
         @(negedge clk);
         start = 1'b1;
         x     = DW'(px[i]);
         if (((i / W) % 2 == 1) && ((i % W) % 2 == 1)) begin
            sb.push_back('{v: DW'(ex[k]), fd: (i == W*H-1), due: cyc + 1});
            k++;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         start = 1'b0;
         x     = '0;
      end
   endtask

   int f1[16]  = '{1, 5, 2, 3,  4, 0, 7, -6,  9, 8, 0, 0,  1, 2, 3, 10};
   int e1[4]   = '{5, 7, 9, 10};
   int f1p[16] = '{101, 105, 102, 103,  104, 100, 107, 94,  109, 108, 100, 100,  101, 102, 103, 110};
   int e1p[4]  = '{105, 107, 109, 110};
   int fn[16]  = '{-5, -3, -8, -7,  -9, -4, -2, -6,  -1, -8, -7, -7,  -3, -2, -8, -8};
   int en[4]   = '{-3, -2, -1, -7};
   int fx[16]  = '{131071, -131072, -131072, -131072,  0, 1, -131072, -131072,
                   5, -131072, -131072, -131072,  -131072, -131072, -131072, -131072};
   int ex[4]   = '{131071, -131072, 5, -131072};

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_output_pixel", output_pixel, 0);
      chk("reset_ready", ready, 0);
      chk("reset_frame_done", frame_done, 0);
      @(negedge clk);
      rst = 1'b1;

      send_frame(f1, e1, 0, 16);
      idle(3);
      send_frame(fn, en, 0, 16);
      idle(2);
      send_frame(f1, e1, 1, 16);
      idle(2);
      send_frame(f1, e1, 2, 16);
      idle(2);

      // Reset after row 1 col 2: only the window completed at row 1 col 1 may appear.
      send_frame(f1, e1, 0, 7);
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b0;
      #1;
      chk("midreset_output_pixel", output_pixel, 0);
      chk("midreset_ready", ready, 0);
      idle(2);
      rst = 1'b1;
      send_frame(f1, e1, 0, 16);

      // Back-to-back frames, no bubble between them.
      send_frame(f1, e1, 0, 16);
      send_frame(f1p, e1p, 0, 16);
      idle(2);
      send_frame(fx, ex, 2, 16);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      idle(4);
      chk("scoreboard_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
